// File: rtl/alu_exec_stage.sv
// Execute stage around a combinational ALU: registers operands, waits for the ALU, captures result.
// Optional sticky overflow flag (ovf_clr / ovf_sticky) when ALU_STICKY_OVF_EN is defined.
module alu_exec_stage #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic             out_overflow
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf_sticky
`endif
);

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  // One cycle for the registered operands to reach the ALU, then EXEC_CYCLES settle cycles.
  localparam logic [3:0] CntLoad = 4'(EXEC_CYCLES);

  state_e           r_state;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_op;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_res;
  logic             r_out_zero;
  logic             r_out_overflow;
  logic             w_capture;

  assign w_capture = (r_state == StExec) && (r_cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_op       <= '0;
      r_out_valid    <= 1'b0;
      r_out_res      <= '0;
      r_out_zero     <= 1'b0;
      r_out_overflow <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_alu_a  <= in_a;
            r_alu_b  <= in_b;
            r_alu_op <= in_op;
            r_cnt    <= CntLoad;
            r_state  <= StExec;
          end
        end
        StExec: begin
          if (w_capture) begin
            r_out_res      <= alu_res;
            r_out_zero     <= alu_zero;
            r_out_overflow <= alu_overflow;
            r_out_valid    <= 1'b1;
            r_state        <= StHold;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StHold: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready     = rst_n && (r_state == StIdle);
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_op       = r_alu_op;
  assign out_valid    = r_out_valid;
  assign out_res      = r_out_res;
  assign out_zero     = r_out_zero;
  assign out_overflow = r_out_overflow;

`ifdef ALU_STICKY_OVF_EN
  logic r_ovf_sticky;

  // A capture with overflow takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_capture && alu_overflow) begin
      r_ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  assign ovf_sticky = r_ovf_sticky;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vectors, backpressure, reset, random ops.
module tb_alu_exec_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_a, in_b, alu_a, alu_b, alu_res, out_res;
  logic [2:0]   in_op, alu_op;
  logic         alu_zero, alu_overflow, out_zero, out_overflow;

  logic         in_valid4, in_ready4, out_valid4, out_ready4;
  logic [W-1:0] in_a4, in_b4, alu_a4, alu_b4, alu_res4, out_res4;
  logic [2:0]   in_op4, alu_op4;
  logic         alu_zero4, alu_overflow4, out_zero4, out_overflow4;

`ifdef ALU_STICKY_OVF_EN
  logic ovf_clr, ovf_sticky, ovf_clr4, ovf_sticky4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(W), .EXEC_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_zero(out_zero), .out_overflow(out_overflow)
`ifdef ALU_STICKY_OVF_EN
    , .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
`endif
  );

  alu_exec_stage #(.WIDTH(W), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_op(in_op4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4),
    .alu_res(alu_res4), .alu_zero(alu_zero4), .alu_overflow(alu_overflow4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_res(out_res4), .out_zero(out_zero4), .out_overflow(out_overflow4)
`ifdef ALU_STICKY_OVF_EN
    , .ovf_clr(ovf_clr4), .ovf_sticky(ovf_sticky4)
`endif
  );

  // Environment ALU, bit-level flags.
  function automatic logic [W+1:0] stub_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
    logic [W-1:0] r;
    logic         v;
    logic [W:0]   d;
    r = '0;
    v = 1'b0;
    d = {1'b0, a} - {1'b0, b};
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        r = a + b;
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b110: begin
        r = a - b;
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b111: r = {{(W-1){1'b0}}, (a[W-1] != b[W-1]) ? a[W-1] : d[W-1]};
      default: r = '0;
    endcase
    return {v, (r == '0), r};
  endfunction

  assign {alu_overflow, alu_zero, alu_res}    = stub_alu(alu_a, alu_b, alu_op);
  assign {alu_overflow4, alu_zero4, alu_res4} = stub_alu(alu_a4, alu_b4, alu_op4);

  // Reference model: signed arithmetic on 64-bit integers, overflow by range.
  function automatic logic [W+1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
    longint       sa, sb, s;
    logic [W-1:0] res;
    logic         ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    s   = 0;
    ovf = 1'b0;
    res = '0;
    case (op)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b010: s = sa + sb;
      3'b110: s = sa - sb;
      3'b111: res = (sa < sb) ? 1 : 0;
      default: res = '0;
    endcase
    if (op == 3'b010 || op == 3'b110) begin
      res = s[W-1:0];
      ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    return {ovf, (res == '0), res};
  endfunction

  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input string tag, input int hold = 0);
    logic [W+1:0] exp;
    int           n;
    exp = ref_alu(a, b, op);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait: in_ready=%b want 1", tag, in_ready);
    end
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s ready_exec: in_ready=%b want 0", tag, in_ready);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL %s latency: got %0d want 2", tag, n);
    end
    for (int i = 0; i <= hold; i++) begin
      checks++;
      if ({out_overflow, out_zero, out_res} !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s result: got v=%b ovf=%b z=%b res=%h rdy=%b want v=1 ovf=%b z=%b res=%h rdy=0",
                 tag, out_valid, out_overflow, out_zero, out_res, in_ready,
                 exp[W+1], exp[W], exp[W-1:0]);
      end
      if (i < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: out_valid=%b in_ready=%b want 0/1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; in_a4 = '0; in_b4 = '0; in_op4 = '0;
`ifdef ALU_STICKY_OVF_EN
    ovf_clr = 1'b0; ovf_clr4 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    checks++;
    if (out_res !== '0 || out_zero !== 1'b0 || out_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: res=%h z=%b ovf=%b want 0", out_res, out_zero, out_overflow);
    end
    checks++;
    if (alu_a !== '0 || alu_b !== '0 || alu_op !== '0) begin
      errors++;
      $display("FAIL reset_alu: a=%h b=%h op=%h want 0", alu_a, alu_b, alu_op);
    end
`ifdef ALU_STICKY_OVF_EN
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_sticky: got %b want 0", ovf_sticky);
    end
`endif
  endtask

  task automatic test_directed();
    do_txn(32'hA5A5A5A5, 32'h5A5A5A5A, 3'b010, "add_basic");
    do_txn(32'hA5A5A5A5, 32'h5A5A5A5A, 3'b000, "and_zero");
    do_txn(32'h7FFFFFFF, 32'h00000001, 3'b010, "add_ovf");
    do_txn(32'h80000000, 32'h00000001, 3'b110, "sub_ovf");
    do_txn(32'hFFFFFFFF, 32'h00000001, 3'b111, "slt_neg");
  endtask

  task automatic test_backpressure();
    logic [W+1:0] exp_x, exp_y;
    int           n;
    exp_x = ref_alu(32'h11111111, 32'h22222222, 3'b010);
    exp_y = ref_alu(32'h0F0F0F0F, 32'h00FF00FF, 3'b001);
    in_valid = 1'b1; in_a = 32'h11111111; in_b = 32'h22222222; in_op = 3'b010;
    @(negedge clk);
    in_a = 32'h0F0F0F0F; in_b = 32'h00FF00FF; in_op = 3'b001;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_overflow, out_zero, out_res} !== exp_x || alu_a !== 32'h11111111 ||
          in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: res=%h alu_a=%h rdy=%b v=%b want res=%h alu_a=11111111 rdy=0 v=1",
                 i, out_res, alu_a, in_ready, out_valid, exp_x[W-1:0]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || alu_a !== 32'h0F0F0F0F || alu_op !== 3'b001) begin
      errors++;
      $display("FAIL bp_next_accept: rdy=%b alu_a=%h op=%h want 0/0f0f0f0f/1", in_ready, alu_a, alu_op);
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({out_overflow, out_zero, out_res} !== exp_y || n !== 2) begin
      errors++;
      $display("FAIL bp_next_result: res=%h lat=%0d want res=%h lat=2", out_res, n, exp_y[W-1:0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int seen;
    in_valid = 1'b1; in_a = 32'h00000003; in_b = 32'h00000004; in_op = 3'b010;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_a !== '0) begin
      errors++;
      $display("FAIL rst_exec: out_valid=%b alu_a=%h want 0/0", out_valid, alu_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_exec_ready: in_ready=%b want 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_exec_no_result: out_valid cycles=%0d want 0", seen);
    end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_res !== '0) begin
      errors++;
      $display("FAIL rst_hold: out_valid=%b res=%h want 0/0", out_valid, out_res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0]   ops [5];
    logic [W-1:0] a, b;
    logic [2:0]   op;
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(4, 0)];
      case ($urandom_range(3, 0))
        0: a = 32'h7FFFFFFF;
        1: a = 32'h80000000;
        default: a = $urandom;
      endcase
      case ($urandom_range(3, 0))
        0: b = a;
        1: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      do_txn(a, b, op, "random", int'($urandom_range(3, 0)));
    end
  endtask

  task automatic test_exec4();
    logic [W-1:0] va [2];
    logic [W-1:0] vb [2];
    logic [2:0]   vo [2];
    logic [W+1:0] exp;
    int           n;
    va = '{32'h01234567, 32'h00000005};
    vb = '{32'h76543210, 32'h00000005};
    vo = '{3'b111, 3'b110};
    for (int i = 0; i < 2; i++) begin
      exp = ref_alu(va[i], vb[i], vo[i]);
      checks++;
      if (in_ready4 !== 1'b1) begin
        errors++;
        $display("FAIL exec4_ready[%0d]: in_ready=%b want 1", i, in_ready4);
      end
      in_valid4 = 1'b1; in_a4 = va[i]; in_b4 = vb[i]; in_op4 = vo[i];
      @(negedge clk);
      in_valid4 = 1'b0;
      n = 0;
      while (!out_valid4 && n < 40) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n !== 5) begin
        errors++;
        $display("FAIL exec4_latency[%0d]: got %0d want 5", i, n);
      end
      checks++;
      if ({out_overflow4, out_zero4, out_res4} !== exp) begin
        errors++;
        $display("FAIL exec4_result[%0d]: ovf=%b z=%b res=%h want ovf=%b z=%b res=%h", i,
                 out_overflow4, out_zero4, out_res4, exp[W+1], exp[W], exp[W-1:0]);
      end
      out_ready4 = 1'b1;
      @(negedge clk);
      out_ready4 = 1'b0;
    end
  endtask

`ifdef ALU_STICKY_OVF_EN
  task automatic test_sticky();
    int n;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clr0: got %b want 0", ovf_sticky);
    end
    do_txn(32'h7FFFFFFF, 32'h00000001, 3'b010, "sticky_set");
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set: got %b want 1", ovf_sticky);
    end
    do_txn(32'h00000001, 32'h00000001, 3'b000, "sticky_keep");
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_keep: got %b want 1", ovf_sticky);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clr: got %b want 0", ovf_sticky);
    end
    ovf_clr = 1'b1;
    in_valid = 1'b1; in_a = 32'h80000000; in_b = 32'h80000000; in_op = 3'b010;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set_wins: got %b want 1", ovf_sticky);
    end
    @(negedge clk);
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clr_after: got %b want 0", ovf_sticky);
    end
    ovf_clr = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    test_exec4();
`ifdef ALU_STICKY_OVF_EN
    test_sticky();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
